// File: rtl/psum_gb_collector.sv
// Merges the three PE partial-sum streams through 2-deep skid FIFOs and a
// round-robin arbiter into the single PSUM global-buffer write port.
module psum_gb_collector #(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              PSUMGB_val0,
  input  logic              PSUMGB_val1,
  input  logic              PSUMGB_val2,
  input  logic [DATA_W-1:0] PSUMGB_data0,
  input  logic [DATA_W-1:0] PSUMGB_data1,
  input  logic [DATA_W-1:0] PSUMGB_data2,
  output logic              GBPSUM_rdy0,
  output logic              GBPSUM_rdy1,
  output logic              GBPSUM_rdy2,
  input  logic              cfg_val,
  input  logic [ADDR_W-1:0] cfg_base0,
  input  logic [ADDR_W-1:0] cfg_base1,
  input  logic [ADDR_W-1:0] cfg_base2,
  input  logic [ADDR_W:0]   cfg_len,
  output logic              gb_wr_en,
  output logic [ADDR_W-1:0] gb_wr_addr,
  output logic [DATA_W-1:0] gb_wr_data,
  input  logic              gb_wr_rdy,
  output logic [2:0]        ch_done,
  output logic              all_done
);
  // state | meaning
  // IDLE  | no tile loaded, inputs blocked
  // RUN   | collecting cfg_len words per channel
  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q;
  logic [ADDR_W:0]   len_q;
  logic [1:0]        last_grant_q;
  logic              out_vld_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  logic              cfg_load, load, grant_vld;
  logic [1:0]        grant, p0, p1, p2;
  logic [2:0]        in_val, push, pop, nonempty, rdy, done;
  logic [DATA_W-1:0] in_data [3];
  logic [ADDR_W-1:0] in_base [3];
  logic [DATA_W-1:0] head    [3];
  logic [ADDR_W-1:0] wr_addr [3];

  assign in_val     = {PSUMGB_val2, PSUMGB_val1, PSUMGB_val0};
  assign in_data[0] = PSUMGB_data0;
  assign in_data[1] = PSUMGB_data1;
  assign in_data[2] = PSUMGB_data2;
  assign in_base[0] = cfg_base0;
  assign in_base[1] = cfg_base1;
  assign in_base[2] = cfg_base2;

  assign cfg_load = (state_q == IDLE) && cfg_val;
  assign load     = !out_vld_q || gb_wr_rdy;

  for (genvar n = 0; n < 3; n++) begin : g_ch
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   acc_cnt_q;
    logic [ADDR_W-1:0] wr_cnt_q;
    logic [1:0]        cnt_q;
    logic [DATA_W-1:0] slot0_q, slot1_q;

    assign nonempty[n] = (cnt_q != 2'd0);
    assign rdy[n]      = (state_q == RUN) && (cnt_q != 2'd2) && (acc_cnt_q < len_q);
    assign done[n]     = (state_q == RUN) && (acc_cnt_q == len_q);
    assign push[n]     = in_val[n] && rdy[n];
    assign pop[n]      = load && grant_vld && (grant == 2'(n));
    assign head[n]     = slot0_q;
    assign wr_addr[n]  = base_q + wr_cnt_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        base_q    <= '0;
        acc_cnt_q <= '0;
        wr_cnt_q  <= '0;
        cnt_q     <= 2'd0;
        slot0_q   <= '0;
        slot1_q   <= '0;
      end else begin
        if (cfg_load) begin
          base_q    <= in_base[n];
          acc_cnt_q <= '0;
          wr_cnt_q  <= '0;
        end else begin
          if (push[n]) acc_cnt_q <= acc_cnt_q + (ADDR_W+1)'(1);
          if (pop[n])  wr_cnt_q  <= wr_cnt_q + ADDR_W'(1);
        end
        // slot0 is always the head; a pop shifts slot1 forward
        case ({push[n], pop[n]})
          2'b10: begin
            if (cnt_q == 2'd0) slot0_q <= in_data[n];
            else               slot1_q <= in_data[n];
            cnt_q <= cnt_q + 2'd1;
          end
          2'b01: begin
            slot0_q <= slot1_q;
            cnt_q   <= cnt_q - 2'd1;
          end
          2'b11: begin
            if (cnt_q == 2'd1) begin
              slot0_q <= in_data[n];
            end else begin
              slot0_q <= slot1_q;
              slot1_q <= in_data[n];
            end
          end
          default: ;
        endcase
      end
    end
  end

  function automatic logic [1:0] rr_next(input logic [1:0] g);
    return (g == 2'd2) ? 2'd0 : g + 2'd1;
  endfunction

  always_comb begin
    p0        = rr_next(last_grant_q);
    p1        = rr_next(p0);
    p2        = rr_next(p1);
    grant_vld = |nonempty;
    if (nonempty[p0])      grant = p0;
    else if (nonempty[p1]) grant = p1;
    else                   grant = p2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      len_q        <= '0;
      last_grant_q <= 2'd2;
      out_vld_q    <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
    end else begin
      case (state_q)
        IDLE: if (cfg_val) begin
          state_q <= RUN;
          len_q   <= cfg_len;
        end
        RUN: if (all_done) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (load) begin
        if (grant_vld) begin
          out_vld_q    <= 1'b1;
          data_q       <= head[grant];
          addr_q       <= wr_addr[grant];
          last_grant_q <= grant;
        end else begin
          out_vld_q <= 1'b0;
        end
      end
    end
  end

  assign GBPSUM_rdy0 = rdy[0];
  assign GBPSUM_rdy1 = rdy[1];
  assign GBPSUM_rdy2 = rdy[2];
  assign ch_done     = done;
  assign all_done    = (done == 3'b111) && !(|nonempty) && !out_vld_q;
  assign gb_wr_en    = out_vld_q;
  assign gb_wr_addr  = addr_q;
  assign gb_wr_data  = data_q;
endmodule

// File: tb/tb_psum_gb_collector.sv
// Directed bench for psum_gb_collector: a queue of expected global-buffer
// writes is filled as words are handed in and drained as writes are accepted.
module tb_psum_gb_collector;
  localparam int DATA_W = 512;
  localparam int ADDR_W = 12;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, cfg_val, gb_wr_rdy;
  logic [2:0]        val;
  logic [DATA_W-1:0] din [3];
  logic [ADDR_W-1:0] cfg_base [3];
  logic [ADDR_W:0]   cfg_len;
  logic              rdy0, rdy1, rdy2, gb_wr_en, all_done;
  logic [2:0]        rdy, ch_done;
  logic [ADDR_W-1:0] gb_wr_addr;
  logic [DATA_W-1:0] gb_wr_data;

  assign rdy = {rdy2, rdy1, rdy0};

  psum_gb_collector #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .PSUMGB_val0(val[0]), .PSUMGB_val1(val[1]), .PSUMGB_val2(val[2]),
    .PSUMGB_data0(din[0]), .PSUMGB_data1(din[1]), .PSUMGB_data2(din[2]),
    .GBPSUM_rdy0(rdy0), .GBPSUM_rdy1(rdy1), .GBPSUM_rdy2(rdy2),
    .cfg_val(cfg_val), .cfg_base0(cfg_base[0]), .cfg_base1(cfg_base[1]),
    .cfg_base2(cfg_base[2]), .cfg_len(cfg_len),
    .gb_wr_en(gb_wr_en), .gb_wr_addr(gb_wr_addr), .gb_wr_data(gb_wr_data),
    .gb_wr_rdy(gb_wr_rdy), .ch_done(ch_done), .all_done(all_done)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int hs_cnt [3];
  logic [ADDR_W-1:0] m_base [3];
  wr_t exp_q [$];
  bit  auto_push;
  int  cyc, wr_acc, wr_en_cyc, first_cyc, last_cyc, mark;
  logic [ADDR_W-1:0] last_addr;

  function automatic logic [DATA_W-1:0] mk(input int c, input int k);
    logic [DATA_W-1:0] w;
    for (int l = 0; l < 16; l++) w[l*32 +: 32] = {8'(c), 8'(k), 8'(l), 8'hA5};
    return w;
  endfunction

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // sample at negedge (handshakes, writes), then drive next words after posedge
  task automatic tick();
    wr_t e;
    @(negedge clk);
    cyc++;
    for (int c = 0; c < 3; c++) begin
      if (val[c] && rdy[c]) begin
        if (auto_push) begin
          e.addr = m_base[c] + ADDR_W'(hs_cnt[c]);
          e.data = mk(c, hs_cnt[c]);
          exp_q.push_back(e);
        end
        hs_cnt[c]++;
      end
    end
    if (gb_wr_en) wr_en_cyc++;
    if (gb_wr_en && gb_wr_rdy) begin
      wr_acc++;
      if (wr_acc == 1) first_cyc = cyc;
      last_cyc  = cyc;
      last_addr = gb_wr_addr;
      if (exp_q.size() == 0) begin
        chk("write_expected", DATA_W'(exp_q.size()), DATA_W'(1));
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", DATA_W'(gb_wr_addr), DATA_W'(e.addr));
        chk("wr_data", gb_wr_data, e.data);
      end
    end
    @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) din[c] = mk(c, hs_cnt[c]);
  endtask

  task automatic do_reset();
    rst = 1'b1; val = 3'b000; cfg_val = 1'b0; gb_wr_rdy = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
    wr_acc = 0;
  endtask

  task automatic do_cfg(input int len, input logic [ADDR_W-1:0] b0, input logic [ADDR_W-1:0] b1,
                        input logic [ADDR_W-1:0] b2);
    cfg_len = (ADDR_W+1)'(len);
    cfg_base[0] = b0; cfg_base[1] = b1; cfg_base[2] = b2;
    m_base[0] = b0; m_base[1] = b1; m_base[2] = b2;
    for (int c = 0; c < 3; c++) hs_cnt[c] = 0;
    wr_acc = 0;
    cfg_val = 1'b1;
    tick();
    cfg_val = 1'b0;
  endtask

  task automatic wait_writes(input string tag, input int n, input int budget);
    int g = 0;
    while (wr_acc < n && g < budget) begin
      tick();
      g++;
    end
    chk(tag, DATA_W'(wr_acc), DATA_W'(n));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rdy"},      DATA_W'(rdy),        '0);
    chk({tag, "_wr_en"},    DATA_W'(gb_wr_en),   '0);
    chk({tag, "_wr_addr"},  DATA_W'(gb_wr_addr), '0);
    chk({tag, "_wr_data"},  gb_wr_data,          '0);
    chk({tag, "_ch_done"},  DATA_W'(ch_done),    '0);
    chk({tag, "_all_done"}, DATA_W'(all_done),   '0);
  endtask

  initial begin
    rst = 1'b1; val = 3'b000; cfg_val = 1'b0; gb_wr_rdy = 1'b0; cfg_len = '0;
    for (int c = 0; c < 3; c++) begin
      din[c] = '0; cfg_base[c] = '0; m_base[c] = '0; hs_cnt[c] = 0;
    end
    auto_push = 1'b1; cyc = 0; wr_acc = 0; wr_en_cyc = 0; first_cyc = 0; last_cyc = 0;
    last_addr = '0;

    do_reset();
    chk_reset_vals("reset");

    // single channel, back-to-back
    do_cfg(4, 12'h100, 12'h000, 12'h000);
    chk("single_rdy_after_cfg", DATA_W'(rdy), DATA_W'(3'b111));
    gb_wr_rdy = 1'b1; val = 3'b001;
    wait_writes("single_writes", 4, 30);
    chk("single_consecutive", DATA_W'(last_cyc - first_cyc), DATA_W'(3));
    chk("single_ch_done", DATA_W'(ch_done), DATA_W'(3'b001));
    chk("single_all_done", DATA_W'(all_done), '0);
    chk("single_q_empty", DATA_W'(exp_q.size()), '0);

    // full contention: expected grant order loaded up front
    do_reset();
    do_cfg(3, 12'h000, 12'h040, 12'h080);
    auto_push = 1'b0;
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < 3; c++) exp_q.push_back('{addr: m_base[c] + ADDR_W'(k), data: mk(c, k)});
    val = 3'b111; gb_wr_rdy = 1'b1;
    wait_writes("cont_writes", 9, 40);
    chk("cont_all_done", DATA_W'(all_done), DATA_W'(1));
    chk("cont_ch_done", DATA_W'(ch_done), DATA_W'(3'b111));
    chk("cont_q_empty", DATA_W'(exp_q.size()), '0);
    tick();
    chk("cont_idle_all_done", DATA_W'(all_done), '0);
    chk("cont_idle_rdy", DATA_W'(rdy), '0);
    auto_push = 1'b1;

    // backpressure on channel 1
    do_reset();
    do_cfg(6, 12'h000, 12'h200, 12'h000);
    gb_wr_rdy = 1'b0; val = 3'b010;
    tick(); tick(); tick();
    chk("bp_en_mid", DATA_W'(gb_wr_en), DATA_W'(1));
    chk("bp_addr_mid", DATA_W'(gb_wr_addr), DATA_W'(12'h200));
    tick(); tick();
    chk("bp_accepted", DATA_W'(hs_cnt[1]), DATA_W'(3));
    chk("bp_rdy1_low", DATA_W'(rdy1), '0);
    chk("bp_en_held", DATA_W'(gb_wr_en), DATA_W'(1));
    chk("bp_addr_held", DATA_W'(gb_wr_addr), DATA_W'(12'h200));
    chk("bp_data_held", gb_wr_data, mk(1, 0));
    gb_wr_rdy = 1'b1;
    wait_writes("bp_writes", 6, 40);
    tick(); tick(); tick();
    chk("bp_en_after", DATA_W'(gb_wr_en), '0);
    chk("bp_q_empty", DATA_W'(exp_q.size()), '0);
    chk("bp_total_in", DATA_W'(hs_cnt[1]), DATA_W'(6));
    chk("bp_ch_done", DATA_W'(ch_done), DATA_W'(3'b010));

    // address wrap on channel 2
    do_reset();
    do_cfg(3, 12'h000, 12'h000, 12'hFFE);
    gb_wr_rdy = 1'b1; val = 3'b100;
    wait_writes("wrap_writes", 3, 30);
    chk("wrap_last_addr", DATA_W'(last_addr), '0);
    chk("wrap_q_empty", DATA_W'(exp_q.size()), '0);

    // zero length tile
    do_reset();
    val = 3'b111; gb_wr_rdy = 1'b1; mark = wr_en_cyc;
    do_cfg(0, 12'h010, 12'h020, 12'h030);
    chk("zl_all_done", DATA_W'(all_done), DATA_W'(1));
    chk("zl_ch_done", DATA_W'(ch_done), DATA_W'(3'b111));
    chk("zl_rdy", DATA_W'(rdy), '0);
    tick();
    chk("zl_idle_all_done", DATA_W'(all_done), '0);
    tick(); tick(); tick();
    chk("zl_no_writes", DATA_W'(wr_en_cyc - mark), '0);

    // reset with two words buffered
    do_reset();
    do_cfg(8, 12'h300, 12'h000, 12'h000);
    gb_wr_rdy = 1'b0; val = 3'b001;
    tick(); tick();
    chk("rst_buffered", DATA_W'(hs_cnt[0]), DATA_W'(2));
    chk("rst_en_before", DATA_W'(gb_wr_en), DATA_W'(1));
    rst = 1'b1;
    tick();
    chk_reset_vals("rst_mid");
    rst = 1'b0; exp_q.delete(); gb_wr_rdy = 1'b1; mark = wr_en_cyc;
    tick(); tick(); tick(); tick();
    chk("rst_no_writes", DATA_W'(wr_en_cyc - mark), '0);
    chk("rst_rdy0_idle", DATA_W'(rdy0), '0);

    // cfg_val while running is ignored
    val = 3'b000;
    do_cfg(4, 12'h500, 12'h000, 12'h000);
    val = 3'b001; gb_wr_rdy = 1'b1;
    tick(); tick();
    cfg_base[0] = 12'h7A0; cfg_len = 13'd9; cfg_val = 1'b1;
    tick();
    cfg_val = 1'b0;
    wait_writes("recfg_writes", 4, 30);
    tick(); tick(); tick();
    chk("recfg_total_in", DATA_W'(hs_cnt[0]), DATA_W'(4));
    chk("recfg_q_empty", DATA_W'(exp_q.size()), '0);
    chk("recfg_ch_done", DATA_W'(ch_done), DATA_W'(3'b001));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
